user_obi_addr_demux: RTL

// Parametrised OBI address demultiplexer for the user domain. One manager port fans out to

---
 rtl/user_obi_addr_demux.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/user_obi_addr_demux.sv
// OBI address demultiplexer: one manager port fans out to NumRules subordinate ports by
// address window. Addresses outside every window go to an internal error subordinate.
// Responses return in order because a new target is only selected once the previous one
// has drained. Error-decoded requests are counted.
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   mgr_*                             manager-side OBI request / response
//   sbr_req_o, sbr_gnt_i              per-port request / grant
//   sbr_addr_o .. sbr_aid_o           request fields broadcast to all ports
//   sbr_rvalid_i .. sbr_rid_i         per-port response fields (port k at slice k)
//   busy_o                            requests outstanding
//   err_count_o                       saturating count of accepted error-decoded requests
module user_obi_addr_demux #(
  parameter int unsigned NumRules  = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1,
  parameter int unsigned MaxTrans  = 4,
  parameter logic [NumRules-1:0][AddrWidth-1:0] RuleStart = {32'h2000_5000, 32'h2000_0000},
  parameter logic [NumRules-1:0][AddrWidth-1:0] RuleEnd   = {32'h2100_5000, 32'h2000_1000},
  parameter logic [DataWidth-1:0] ErrRdata = 32'hBADC_AB1E
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            mgr_req_i,
  output logic                            mgr_gnt_o,
  input  logic [AddrWidth-1:0]            mgr_addr_i,
  input  logic                            mgr_we_i,
  input  logic [DataWidth/8-1:0]          mgr_be_i,
  input  logic [DataWidth-1:0]            mgr_wdata_i,
  input  logic [IdWidth-1:0]              mgr_aid_i,
  output logic                            mgr_rvalid_o,
  output logic [DataWidth-1:0]            mgr_rdata_o,
  output logic                            mgr_err_o,
  output logic [IdWidth-1:0]              mgr_rid_o,
  output logic [NumRules-1:0]             sbr_req_o,
  input  logic [NumRules-1:0]             sbr_gnt_i,
  output logic [AddrWidth-1:0]            sbr_addr_o,
  output logic                            sbr_we_o,
  output logic [DataWidth/8-1:0]          sbr_be_o,
  output logic [DataWidth-1:0]            sbr_wdata_o,
  output logic [IdWidth-1:0]              sbr_aid_o,
  input  logic [NumRules-1:0]             sbr_rvalid_i,
  input  logic [NumRules*DataWidth-1:0]   sbr_rdata_i,
  input  logic [NumRules-1:0]             sbr_err_i,
  input  logic [NumRules*IdWidth-1:0]     sbr_rid_i,
  output logic                            busy_o,
  output logic [15:0]                     err_count_o
);

  localparam int unsigned SelWidth = $clog2(NumRules + 1);
  localparam int unsigned CntWidth = $clog2(MaxTrans + 1);
  localparam logic [SelWidth-1:0] ErrSel = SelWidth'(NumRules);

  logic [SelWidth-1:0] sel;
  logic [SelWidth-1:0] last_sel;
  logic [CntWidth-1:0] cnt;
  logic                stall;
  logic                handshake;
  logic                rsp_valid;
  logic                rsp_fire;
  logic [NumRules-1:0] rsp_mask;
  logic                err_rvalid;
  logic [IdWidth-1:0]  err_rid;

  // Address decode; scanning downwards lets the lowest matching window win
  always_comb begin
    sel = ErrSel;
    for (int k = int'(NumRules) - 1; k >= 0; k--) begin
      if (RuleStart[k] < RuleEnd[k] && mgr_addr_i >= RuleStart[k] && mgr_addr_i < RuleEnd[k]) begin
        sel = SelWidth'(k);
      end
    end
  end

  // Switching target with requests in flight could reorder responses, so hold off
  assign stall = ((cnt != '0) && (sel != last_sel)) || (cnt == CntWidth'(MaxTrans));

  // Request routing; the error subordinate grants immediately
  always_comb begin
    sbr_req_o = '0;
    mgr_gnt_o = 1'b0;
    if (!stall) begin
      if (sel == ErrSel) begin
        mgr_gnt_o = mgr_req_i;
      end
      for (int k = 0; k < int'(NumRules); k++) begin
        if (sel == SelWidth'(k)) begin
          sbr_req_o[k] = mgr_req_i;
          mgr_gnt_o    = sbr_gnt_i[k];
        end
      end
    end
  end

  assign sbr_addr_o  = mgr_addr_i;
  assign sbr_we_o    = mgr_we_i;
  assign sbr_be_o    = mgr_be_i;
  assign sbr_wdata_o = mgr_wdata_i;
  assign sbr_aid_o   = mgr_aid_i;

  assign handshake = mgr_req_i & mgr_gnt_o;

  // Response mux from the port that owns the outstanding requests
  always_comb begin
    rsp_valid   = err_rvalid;
    mgr_rdata_o = ErrRdata;
    mgr_err_o   = 1'b1;
    mgr_rid_o   = err_rid;
    rsp_mask    = '0;
    for (int k = 0; k < int'(NumRules); k++) begin
      if (last_sel == SelWidth'(k)) begin
        rsp_valid   = sbr_rvalid_i[k];
        mgr_rdata_o = sbr_rdata_i[k*DataWidth +: DataWidth];
        mgr_err_o   = sbr_err_i[k];
        mgr_rid_o   = sbr_rid_i[k*IdWidth +: IdWidth];
        rsp_mask[k] = (cnt != '0);
      end
    end
  end

  // Responses with nothing outstanding are dropped
  assign rsp_fire     = rsp_valid & (cnt != '0);
  assign mgr_rvalid_o = rsp_fire;
  assign busy_o       = (cnt != '0);

  // Outstanding tracking; stall and rsp_fire gating keep cnt within 0..MaxTrans
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt      <= '0;
      last_sel <= '0;
    end else begin
      if (handshake) begin
        last_sel <= sel;
      end
      if (handshake && !rsp_fire) begin
        cnt <= cnt + CntWidth'(1);
      end else if (!handshake && rsp_fire) begin
        cnt <= cnt - CntWidth'(1);
      end
    end
  end

  // Error subordinate: fixed one-cycle response to every accepted unmatched request
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_rvalid  <= 1'b0;
      err_rid     <= '0;
      err_count_o <= '0;
    end else begin
      err_rvalid <= handshake && (sel == ErrSel);
      if (handshake && (sel == ErrSel)) begin
        err_rid <= mgr_aid_i;
        if (err_count_o != 16'hFFFF) begin
          err_count_o <= err_count_o + 16'd1;
        end
      end
    end
  end

  // Flag responses arriving on a port that has nothing outstanding
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert ((sbr_rvalid_i & ~rsp_mask) == '0)
        else $warning("user_obi_addr_demux: unexpected response dropped, rvalid=%b", sbr_rvalid_i);
    end
  end

endmodule
